// File: rtl/dvi_pkg.sv
// Shared DVI link definitions: symbol width, control tokens and small helpers
// used by the per-channel TMDS encoder and the downstream serializer.
package dvi_pkg;

  localparam int TMDS_W    = 10;
  localparam int SER_RATIO = TMDS_W;

  localparam logic [TMDS_W-1:0] TOKEN_CTRL00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TOKEN_CTRL01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TOKEN_CTRL10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TOKEN_CTRL11 = 10'b1010101011;

  // Which of the three DC-balance rules applies to a video symbol.
  typedef enum logic [1:0] {
    DC_NEUTRAL = 2'd0,
    DC_INVERT  = 2'd1,
    DC_KEEP    = 2'd2
  } dc_case_e;

  typedef struct packed {
    logic [8:0] qm;
    logic [3:0] n1;
    logic [3:0] n0;
    logic       de;
    logic [1:0] ctrl;
  } qm_stage_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  function automatic logic [TMDS_W-1:0] ctrl_token(input logic [1:0] c);
    logic [TMDS_W-1:0] t;
    unique case (c)
      2'b00:   t = TOKEN_CTRL00;
      2'b01:   t = TOKEN_CTRL01;
      2'b10:   t = TOKEN_CTRL10;
      default: t = TOKEN_CTRL11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel: pixel/control in, 10-bit symbol out.
interface tmds_encoder_if;
  import dvi_pkg::*;

  logic [7:0]        data_i;
  logic [1:0]        ctrl_i;
  logic              de_i;
  logic [TMDS_W-1:0] tmds_o;

  modport master (output data_i, output ctrl_i, output de_i, input tmds_o);
  modport slave  (input data_i, input ctrl_i, input de_i, output tmds_o);

endinterface

// File: rtl/tmds_encoder_qm.sv
// First encoder stage: transition-minimised q_m word plus its ones/zeros
// counts, registered together with de/ctrl so stage 2 sees one coherent record.
module tmds_qm_stage
  import dvi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  input  logic       de_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1_o,
  output logic [3:0] n0_o,
  output logic       de_o,
  output logic [1:0] ctrl_o
);

  // XNOR chain is chosen for bytes heavy in ones; bit 8 records which chain ran.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1d;
    logic       use_xnor;
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  qm_stage_t p1_d, p1_q;

  always_comb begin
    p1_d      = '0;
    p1_d.qm   = qm_encode(data_i);
    p1_d.n1   = popcount8(p1_d.qm[7:0]);
    p1_d.n0   = 4'd8 - p1_d.n1;
    p1_d.de   = de_i;
    p1_d.ctrl = ctrl_i;
  end

  // ---- stage p1 register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_q <= '0;
    end else begin
      p1_q <= p1_d;
    end
  end

  assign qm_o   = p1_q.qm;
  assign n1_o   = p1_q.n1;
  assign n0_o   = p1_q.n0;
  assign de_o   = p1_q.de;
  assign ctrl_o = p1_q.ctrl;

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel DVI TMDS encoder: q_m stage followed by the running-disparity
// stage that picks inversion and emits control tokens during blanking.
module tmds_encoder
  import dvi_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tmds_encoder_if.slave  bus
);

  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

  logic [8:0] qm_p1;
  logic [3:0] n1_p1;
  logic [3:0] n0_p1;
  logic       de_p1;
  logic [1:0] ctrl_p1;

  tmds_qm_stage u_qm (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (bus.data_i),
    .ctrl_i (bus.ctrl_i),
    .de_i   (bus.de_i),
    .qm_o   (qm_p1),
    .n1_o   (n1_p1),
    .n0_o   (n0_p1),
    .de_o   (de_p1),
    .ctrl_o (ctrl_p1)
  );

  // Counts are 0..8, so zero-extension keeps them positive in the signed domain.
  function automatic logic signed [CNT_W-1:0] cnt_ext(input logic [3:0] v);
    return $signed({{(CNT_W-4){1'b0}}, v});
  endfunction

  function automatic logic signed [CNT_W-1:0] twice_bit(input logic b);
    return b ? $signed(CNT_W'(2)) : CNT_ZERO;
  endfunction

  logic signed [CNT_W-1:0] diff10;
  logic signed [CNT_W-1:0] diff01;
  logic                    qm8;
  dc_case_e                dc_case;

  logic [TMDS_W-1:0]       tmds_p2_d, tmds_p2_q;
  logic signed [CNT_W-1:0] cnt_p2_d,  cnt_p2_q;

  assign qm8    = qm_p1[8];
  assign diff10 = cnt_ext(n1_p1) - cnt_ext(n0_p1);
  assign diff01 = cnt_ext(n0_p1) - cnt_ext(n1_p1);

  always_comb begin
    dc_case = DC_KEEP;
    if ((cnt_p2_q == CNT_ZERO) || (n1_p1 == n0_p1)) begin
      dc_case = DC_NEUTRAL;
    end else if (((cnt_p2_q > CNT_ZERO) && (n1_p1 > n0_p1)) ||
                 ((cnt_p2_q < CNT_ZERO) && (n0_p1 > n1_p1))) begin
      dc_case = DC_INVERT;
    end
  end

  always_comb begin
    tmds_p2_d = tmds_p2_q;
    cnt_p2_d  = cnt_p2_q;
    if (!de_p1) begin
      // Blanking resets disparity so each active line starts balanced.
      tmds_p2_d = ctrl_token(ctrl_p1);
      cnt_p2_d  = CNT_ZERO;
    end else begin
      unique case (dc_case)
        DC_NEUTRAL: begin
          tmds_p2_d = {~qm8, qm8, (qm8 ? qm_p1[7:0] : ~qm_p1[7:0])};
          cnt_p2_d  = cnt_p2_q + (qm8 ? diff10 : diff01);
        end
        DC_INVERT: begin
          tmds_p2_d = {1'b1, qm8, ~qm_p1[7:0]};
          cnt_p2_d  = cnt_p2_q + twice_bit(qm8) + diff01;
        end
        default: begin
          tmds_p2_d = {1'b0, qm8, qm_p1[7:0]};
          cnt_p2_d  = cnt_p2_q + diff10 - twice_bit(~qm8);
        end
      endcase
    end
  end

  // ---- stage p2 register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmds_p2_q <= TOKEN_CTRL00;
      cnt_p2_q  <= CNT_ZERO;
    end else begin
      tmds_p2_q <= tmds_p2_d;
      cnt_p2_q  <= cnt_p2_d;
    end
  end

  assign bus.tmds_o = tmds_p2_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vector table plus a random stream scored
// against an arithmetic reference of the TMDS rules.
module tb_tmds_encoder;
  import dvi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmds_encoder_if bus ();

  tmds_encoder #(.CNT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference pipeline state: the symbol waiting in stage 1 and the disparity.
  int         m_cnt   = 0;
  logic       m_de1   = 1'b0;
  logic [1:0] m_ctrl1 = 2'b00;
  logic [7:0] m_data1 = 8'h00;
  logic [9:0] m_out   = 10'h354;

  function automatic logic [9:0] ref_sym(input logic de, input logic [1:0] c,
                                         input logic [7:0] d, inout int cnt);
    logic [8:0] qm;
    int n1d, n1, n0, q8;
    bit use_xnor;
    if (!de) begin
      cnt = 0;
      case (c)
        2'b00:   return 10'b1101010100;
        2'b01:   return 10'b0010101011;
        2'b10:   return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1d = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = use_xnor ? 0 : 1;
    qm[8] = q8[0];
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      cnt = cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
      return {~qm[8], qm[8], (q8 == 1) ? qm[7:0] : ~qm[7:0]};
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      cnt = cnt + 2 * q8 + (n0 - n1);
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cnt = cnt + (n1 - n0) - 2 * (1 - q8);
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic apply(input logic r, input logic de, input logic [1:0] c,
                       input logic [7:0] d);
    rst = r;
    bus.de_i = de;
    bus.ctrl_i = c;
    bus.data_i = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_out = 10'h354;
      m_cnt = 0;
      m_de1 = 1'b0;
      m_ctrl1 = 2'b00;
      m_data1 = 8'h00;
    end else begin
      m_out = ref_sym(m_de1, m_ctrl1, m_data1, m_cnt);
      m_de1 = de;
      m_ctrl1 = c;
      m_data1 = d;
    end
  endtask

  task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: tmds_o=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cnt=%0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] exp_tmds;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int act_cnt;
    logic r, de;
    logic [1:0] c;
    logic [7:0] d;

    // Each row: inputs driven before an edge, symbol/disparity expected after it.
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 8'h00, 10'h354, 0};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 8'h00, 10'h354, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 8'h00, 10'h0AB, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h2AB, 0};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 8'h00, 10'h100, -8};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h3FF, 2};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, 8'hFF, 10'h100, -6};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h354, 0};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 8'hFF, 10'h100, -8};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 8'h00, 10'h0FF, -2};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 8'hFF, 10'h154, 0};
    vecs[13] = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h200, -8};
    vecs[14] = '{1'b1, 1'b1, 2'b00, 8'h00, 10'h354, 0};
    vecs[15] = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h354, 0};
    vecs[16] = '{1'b0, 1'b1, 2'b00, 8'h00, 10'h100, -8};
    vecs[17] = '{1'b0, 1'b0, 2'b00, 8'h00, 10'h3FF, 2};
    vecs[18] = '{1'b0, 1'b1, 2'b00, 8'h1E, 10'h354, 0};
    vecs[19] = '{1'b0, 1'b1, 2'b00, 8'h1E, 10'h25F, 4};
    vecs[20] = '{1'b0, 1'b1, 2'b00, 8'h1E, 10'h0A0, -2};
    vecs[21] = '{1'b0, 1'b0, 2'b00, 8'h00, 10'h25F, 2};
    vecs[22] = '{1'b0, 1'b0, 2'b00, 8'h00, 10'h354, 0};

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].rst, vecs[i].de, vecs[i].ctrl, vecs[i].data);
      act_cnt = dut.cnt_p2_q;
      check_sym($sformatf("vec%0d_tmds", i), bus.tmds_o, vecs[i].exp_tmds);
      check_cnt($sformatf("vec%0d_cnt", i), act_cnt, vecs[i].exp_cnt);
    end

    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      de = ($urandom_range(0, 9) != 0);
      c  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        default: d = 8'($urandom_range(0, 255));
      endcase
      apply(r, de, c, d);
      act_cnt = dut.cnt_p2_q;
      check_sym($sformatf("rand%0d_tmds", n), bus.tmds_o, m_out);
      check_cnt($sformatf("rand%0d_cnt", n), act_cnt, m_cnt);
      checks++;
      if (act_cnt > 10 || act_cnt < -10) begin
        errors++;
        $display("FAIL rand%0d_cnt_bound: cnt=%0d required within -10..10", n, act_cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
